// File: rtl/aes_key_pkg.sv
// Shared key-length encodings, FSM states and tag helpers for the AES key-slot cache.
// No logic of its own: types and pure functions only.
package aes_key_pkg;

    localparam logic [1:0] KL_NONE = 2'b00;
    localparam logic [1:0] KL_128  = 2'b01;
    localparam logic [1:0] KL_192  = 2'b10;
    localparam logic [1:0] KL_256  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_START,
        ST_FILL,
        ST_RESP
    } state_e;

    // Cached context identity: length plus key with the unused low bits zeroed.
    typedef struct packed {
        logic [1:0]   len;
        logic [255:0] key;
    } tag_t;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KL_192:  return 4'd13;
            KL_256:  return 4'd15;
            default: return 4'd11;
        endcase
    endfunction

    function automatic logic [255:0] key_mask(input logic [1:0] len);
        case (len)
            KL_128:  return {{128{1'b1}}, {128{1'b0}}};
            KL_192:  return {{192{1'b1}}, {64{1'b0}}};
            KL_256:  return {256{1'b1}};
            default: return {256{1'b0}};
        endcase
    endfunction

endpackage

// File: rtl/aes_key_tag_cam.sv
// Tag store for the key-slot cache: parallel match, victim choice, RR pointer.
// Latency: match and victim are combinational; writes, invalidates and flush land on the next edge.
// Backpressure: none, the controller sequences all accesses.
module aes_key_tag_cam
    import aes_key_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  tag_t              lookup_tag,
    output logic              hit,
    output logic [SLOT_W-1:0] hit_slot,
    output logic [SLOT_W-1:0] victim_slot,
    input  logic              alloc_en,
    input  logic              inval_en,
    input  logic [SLOT_W-1:0] inval_slot,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  tag_t              wr_tag,
    input  logic              flush
);

    tag_t                 tag_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q;
    logic [NUM_SLOTS-1:0] valid_d;
    logic [NUM_SLOTS-1:0] match;
    logic [SLOT_W-1:0]    rr_q;
    logic [SLOT_W-1:0]    free_slot;
    logic                 any_free;

    always_comb begin
        match     = '0;
        hit_slot  = '0;
        free_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == lookup_tag);
        end
        // Descending scan so the lowest index wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_slot = SLOT_W'(i);
            end
            if (!valid_q[i]) begin
                free_slot = SLOT_W'(i);
            end
        end
        hit         = |match;
        any_free    = ~&valid_q;
        victim_slot = any_free ? free_slot : rr_q;
    end

    // A completing fill re-validates its slot even when flush lands in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (inval_en) begin
            valid_d[inval_slot] = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
        end
        if (wr_en) begin
            valid_d[wr_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (alloc_en && !any_free) begin
                rr_q <= (rr_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_slot] <= wr_tag;
        end
    end

endmodule

// File: rtl/aes_key_slot_ctrl.sv
// Multi-slot AES key-schedule cache controller; KEY_SLOT_STATS_EN adds hit/miss counters.
// Latency: hit or error response 2 cycles after acceptance; miss response 2 cycles after the last subkey.
// Backpressure: req_ready is high only in IDLE; one request in flight at a time.
module aes_key_slot_ctrl
    import aes_key_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [255:0]        req_key,
    input  logic [1:0]          req_key_len,
    input  logic                flush,
    output logic                rsp_valid,
    output logic [SLOT_W-1:0]   rsp_slot,
    output logic                rsp_hit,
    output logic                rsp_err,
    output logic                exp_start,
    output logic [255:0]        exp_key,
    output logic [1:0]          exp_key_len,
    input  logic                exp_valid,
    input  logic [3:0]          exp_waddr,
    input  logic [127:0]        exp_subkey,
    output logic                mem_we,
    output logic [SLOT_W+3:0]   mem_waddr,
    output logic [127:0]        mem_wdata,
    output logic                busy
`ifdef KEY_SLOT_STATS_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    state_e            state_q, state_d;
    logic [255:0]      key_q;
    logic [1:0]        len_q;
    logic [SLOT_W-1:0] victim_q;
    logic [SLOT_W-1:0] slot_q;
    logic              hit_q;
    logic              err_q;
    logic [3:0]        cnt_q;
    logic [3:0]        nk;
    tag_t              cur_tag;
    logic              cam_hit;
    logic [SLOT_W-1:0] cam_hit_slot;
    logic [SLOT_W-1:0] cam_victim;
    logic              len_err;
    logic              lookup_hit;
    logic              fill_wr;
    logic              alloc_en;
    logic              inval_en;
    logic              tag_wr;

    assign nk          = nk_of(len_q);
    assign cur_tag.len = len_q;
    assign cur_tag.key = key_q & key_mask(len_q);
    assign len_err     = (len_q == KL_NONE);
    // A flush sampled during lookup must not return a slot it is invalidating.
    assign lookup_hit  = cam_hit && !flush && !len_err;
    assign fill_wr     = (state_q == ST_FILL) && exp_valid && (exp_waddr < nk);

    aes_key_tag_cam #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_tag_cam (
        .clk         (clk),
        .reset       (reset),
        .lookup_tag  (cur_tag),
        .hit         (cam_hit),
        .hit_slot    (cam_hit_slot),
        .victim_slot (cam_victim),
        .alloc_en    (alloc_en),
        .inval_en    (inval_en),
        .inval_slot  (victim_q),
        .wr_en       (tag_wr),
        .wr_slot     (victim_q),
        .wr_tag      (cur_tag),
        .flush       (flush)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alloc_en  = 1'b0;
        inval_en  = 1'b0;
        tag_wr    = 1'b0;
        exp_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (len_err || lookup_hit) begin
                    state_d = ST_RESP;
                end else begin
                    alloc_en = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                inval_en  = 1'b1;
                exp_start = 1'b1;
                state_d   = ST_FILL;
            end
            ST_FILL: begin
                if (cnt_q == nk) begin
                    tag_wr  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q    <= '0;
            len_q    <= KL_NONE;
            victim_q <= '0;
            slot_q   <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        key_q <= req_key;
                        len_q <= req_key_len;
                    end
                end
                ST_LOOKUP: begin
                    err_q    <= len_err;
                    hit_q    <= lookup_hit;
                    victim_q <= cam_victim;
                    if (len_err) begin
                        slot_q <= '0;
                    end else if (lookup_hit) begin
                        slot_q <= cam_hit_slot;
                    end else begin
                        slot_q <= cam_victim;
                    end
                end
                ST_START: begin
                    cnt_q <= '0;
                end
                ST_FILL: begin
                    if (fill_wr) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_slot    = rsp_valid ? slot_q : '0;
    assign rsp_hit     = rsp_valid && hit_q;
    assign rsp_err     = rsp_valid && err_q;
    assign exp_key     = key_q;
    assign exp_key_len = len_q;
    assign mem_we      = fill_wr;
    assign mem_waddr   = fill_wr ? {victim_q, exp_waddr} : '0;
    assign mem_wdata   = fill_wr ? exp_subkey : '0;

`ifdef KEY_SLOT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rsp_valid && !err_q) begin
            if (hit_q) begin
                if (hit_cnt != 32'hFFFF_FFFF) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else if (miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/aes_key_slot_ctrl.md
# aes_key_slot_ctrl

Multi-slot key-schedule cache controller for the AES accelerator. It replaces the single last-key compare with NUM_SLOTS cached expanded keys. It accepts key requests over a valid/ready handshake and answers hits in 2 cycles without re-expansion. On a miss it drives a shared key-expansion engine and writes the round keys into a slotted round-key memory.

## Interface
Parameters:
- NUM_SLOTS, default 4: number of cached key contexts; power of two, 2..16. SLOT_W = clog2(NUM_SLOTS) is derived.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  key request
- req_ready  out  1  high only in IDLE
- req_key  in  256  key, MSB-aligned
- req_key_len  in  2  01=128, 10=192, 11=256, 00=invalid
- flush  in  1  invalidate all cached slots
- rsp_valid  out  1  one-cycle response pulse
- rsp_slot  out  SLOT_W  slot holding the key schedule
- rsp_hit  out  1  1 = served from cache
- rsp_err  out  1  1 = key_len 00; no slot assigned
- exp_start  out  1  one-cycle start pulse to the expansion engine
- exp_key  out  256  registered request key
- exp_key_len  out  2  registered request length
- exp_valid  in  1  engine subkey strobe
- exp_waddr  in  4  engine subkey index
- exp_subkey  in  128  engine subkey
- mem_we  out  1  round-key memory write
- mem_waddr  out  SLOT_W+4  {slot, exp_waddr}
- mem_wdata  out  128  exp_subkey
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOOKUP, START, FILL, RESP.
- IDLE -> LOOKUP on req_valid & req_ready. The key and length are registered on acceptance.
- Tag format:
  - The tag is the masked key plus the length.
  - Unused bits are zeroed: [127:0] for 128-bit keys, [63:0] for 192-bit keys.
  - A hit requires tag_valid, an equal length and an equal masked key.
- LOOKUP:
  - key_len 00 -> RESP with rsp_err=1.
  - Hit -> RESP with rsp_hit=1 and rsp_slot = matching slot.
  - Miss -> START.
- Victim selection on a miss:
  - Use the lowest-index invalid slot if one exists.
  - Otherwise use the round-robin pointer. The pointer advances (wrapping NUM_SLOTS-1 -> 0) only when it supplies the victim.
- START: clear the victim's tag_valid, pulse exp_start, go to FILL.
- FILL:
  - Each exp_valid with exp_waddr < NK produces mem_we = 1, addressed {victim, exp_waddr}. NK = 11/13/15 for 128/192/256.
  - A received-subkey counter increments on each such write. Writes with exp_waddr >= NK are dropped.
  - When the counter reaches NK: write the victim's tag, set tag_valid, go to RESP with rsp_hit=0.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- exp_valid outside FILL is ignored.
- flush:
  - Clears every tag_valid in the cycle it is sampled, in any state.
  - In LOOKUP, a simultaneous flush forces a miss.
  - A slot being filled during a flush still becomes valid at FILL end.
- reset mid-operation: return to IDLE immediately. The in-flight fill is abandoned; no tag is written.

## Timing
- Reset values: req_ready=1 (in IDLE after reset). All other outputs 0: rsp_valid, rsp_slot, rsp_hit, rsp_err, exp_start, mem_we, mem_waddr, mem_wdata, exp_key, exp_key_len, busy. All tags invalid; RR pointer 0; counter 0.
- Hit latency: acceptance edge T -> rsp_valid during cycle T+2.
- Miss latency:
  - exp_start is high during T+2.
  - mem_we is combinational from exp_valid in FILL (same cycle).
  - rsp_valid occurs 2 cycles after the NK-th valid subkey: FILL -> RESP, then RESP.
- req_ready is low from acceptance until the cycle after rsp_valid.

## Configuration
- KEY_SLOT_STATS_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both saturating at 0xFFFFFFFF and cleared by reset.
  - Each increments once per non-error response.
  - flush does not clear them.
- KEY_SLOT_STATS_EN undefined: the ports and logic are absent.

## Structure
- Package aes_key_pkg:
  - key-length encodings KL_NONE/KL_128/KL_192/KL_256
  - function nk_of(len) returning 11/13/15
  - FSM state enum
  - key_mask(len) function
- Sub-module aes_key_tag_cam:
  - tag registers and valid bits
  - parallel match, producing hit and hit_slot
  - victim selection and RR pointer
  - flush and tag write ports

## Test plan
- Reset, request 128-bit key 0x000102…0F -> miss. exp_start at T+2; 11 writes to addresses 0x00..0x0A; rsp_slot=0, rsp_hit=0.
- Repeat the same key -> rsp_valid at T+2 with rsp_hit=1, rsp_slot=0, no exp_start.
- Same upper 128 bits with len=11 -> miss, slot 1, 15 writes to 0x10..0x1E. Len=01 repeat still hits slot 0.
- NUM_SLOTS=4: fill 4 distinct keys, then 2 new keys -> victims 0 then 1 (RR). The evicted key then misses.
- flush during FILL of slot 2 -> slots 0,1,3 miss afterward; the slot 2 key hits.
- key_len=00 -> rsp_err=1 at T+2, no mem_we. Reset asserted mid-FILL -> IDLE, the key misses on retry.
